lcd_column_expander: RTL

Parametrised successor to the LCD column converter. Accepts narrow RAM words through a valid/ready handshake, buffers them in a small FIFO, and at a fixed pacing interval expands each bit into an EXP-bit segment framed by border bits. Presents the result as a held column word with valid/ready toward the LCD driver. Adds run-time invert and mirror modes and underrun reporting.

---
 rtl/lcd_conv_pkg.sv | 24 ++
 rtl/lcd_column_expander_if.sv | 26 ++
 rtl/lcd_col_fifo.sv | 52 +++++
 rtl/lcd_column_expander.sv | 106 ++++++++++
 4 files changed

// File: rtl/lcd_conv_pkg.sv
// Shared LCD column conversion defaults and helpers.
// The column expander and the LCD driver both take their geometry from here.
package lcd_conv_pkg;

  localparam int   IN_W_DEF       = 10;
  localparam int   EXP_DEF        = 6;
  localparam int   BORDER_DEF     = 2;
  localparam int   PERIOD_DEF     = 6;
  localparam int   FIFO_DEPTH_DEF = 2;
  localparam logic BORDER_VAL_DEF = 1'b1;

  // What happens at a pacing load opportunity.
  typedef enum logic [1:0] {
    LD_IDLE,
    LD_POP,
    LD_HOLD,
    LD_UNDERRUN
  } load_act_e;

  function automatic int out_w(input int in_w, input int exp, input int border);
    return in_w * exp + 2 * border;
  endfunction

endpackage

// File: rtl/lcd_column_expander_if.sv
// RAM-word input stream, mode controls and expanded column output stream.
// slave is the expander side; master is the RAM/driver side.
interface lcd_column_expander_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 64
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             invert;
  logic             mirror;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             underrun;

  modport slave (
    input  in_data, in_valid, invert, mirror, out_ready,
    output in_ready, out_data, out_valid, underrun
  );

  modport master (
    output in_data, in_valid, invert, mirror, out_ready,
    input  in_ready, out_data, out_valid, underrun
  );
endinterface

// File: rtl/lcd_col_fifo.sv
// Small synchronous FIFO buffering RAM words ahead of the column expander.
// Head word is visible on rd_data whenever the FIFO is non-empty; no fall-through.
module lcd_col_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wr_data,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_column_expander.sv
// Buffers RAM words and, on a fixed pacing grid, expands each bit into an
// EXP-bit segment framed by border bits, holding the column for the LCD driver.
module lcd_column_expander
  import lcd_conv_pkg::*;
#(
  parameter int   IN_W       = IN_W_DEF,
  parameter int   EXP        = EXP_DEF,
  parameter int   BORDER     = BORDER_DEF,
  parameter logic BORDER_VAL = BORDER_VAL_DEF,
  parameter int   PERIOD     = PERIOD_DEF,
  parameter int   FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_column_expander_if.slave  bus
);

  localparam int OUT_W = out_w(IN_W, EXP, BORDER);
  localparam int TW    = $clog2(PERIOD);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [TW-1:0]    tick;
  logic [IN_W-1:0]  head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  load_act_e        act;
  logic [OUT_W-1:0] expanded;
  logic [OUT_W-1:0] col_q;
  logic             valid_q;
  logic             underrun_q;

  assign bus.in_ready = (fifo_count != FULL_CNT);
  assign push         = bus.in_valid & ~fifo_full;
  assign slot_free    = ~valid_q | bus.out_ready;
  assign pop          = (act == LD_POP);

  lcd_col_fifo #(
    .W     (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.in_data),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Free-running pacing grid; load opportunities never slip.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= '0;
    else if (tick == TICK_LAST) tick <= '0;
    else tick <= tick + 1'b1;
  end

  always_comb begin
    act = LD_IDLE;
    if (tick == TICK_LAST) begin
      if (fifo_empty)     act = LD_UNDERRUN;
      else if (slot_free) act = LD_POP;
      else                act = LD_HOLD;
    end
  end

  for (genvar k = 0; k < IN_W; k++) begin : g_seg
    logic seg_bit;
    assign seg_bit = (bus.mirror ? head[IN_W-1-k] : head[k]) ^ bus.invert;
    assign expanded[BORDER+EXP*k +: EXP] = {EXP{seg_bit}};
  end

  if (BORDER > 0) begin : g_border
    assign expanded[0 +: BORDER]           = {BORDER{BORDER_VAL}};
    assign expanded[OUT_W-BORDER +: BORDER] = {BORDER{BORDER_VAL}};
  end

  // invert/mirror only matter at the pop edge; the held column ignores later changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= (act == LD_UNDERRUN);
      if (act == LD_POP) begin
        col_q   <= expanded;
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = col_q;
  assign bus.out_valid = valid_q;
  assign bus.underrun  = underrun_q;

endmodule
